// File: rtl/mult_seq_ctrl.sv
// Control FSM for a shift-add sequential multiplier: sequences load/clear/add/shift strobes.
// Optional MULT_PERF_CNT_EN adds a last_cycles output reporting the duration of the previous operation.
module mult_seq_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       q0,
  output logic       ld_a,
  output logic       ld_b,
  output logic       clr_p,
  output logic       ld_p,
  output logic       shift,
  output logic       busy,
  output logic       done
`ifdef MULT_PERF_CNT_EN
  ,
  output logic [7:0] last_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == LOAD) begin
        cnt <= '0;
      end else if (state == SHIFT && !last_iter) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    clr_p      = 1'b0;
    ld_p       = 1'b0;
    shift      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        ld_a       = 1'b1;
        ld_b       = 1'b1;
        clr_p      = 1'b1;
        busy       = 1'b1;
        state_next = TEST;
      end
      TEST: begin
        busy       = 1'b1;
        state_next = q0 ? ADD : SHIFT;
      end
      ADD: begin
        ld_p       = 1'b1;
        busy       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        shift      = 1'b1;
        busy       = 1'b1;
        state_next = last_iter ? DONE : TEST;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MULT_PERF_CNT_EN
  // perf_cnt reads 1 during LOAD so that in DONE it equals the inclusive LOAD..DONE cycle count.
  logic [7:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      perf_cnt    <= '0;
      last_cycles <= '0;
    end else begin
      if (state == IDLE && start) begin
        perf_cnt <= 8'd1;
      end else if (state != IDLE && state != DONE && perf_cnt != 8'hFF) begin
        perf_cnt <= perf_cnt + 8'd1;
      end
      if (state == DONE) last_cycles <= perf_cnt;
    end
  end
`endif

endmodule
